// File: rtl/bit_field_packer.sv
// Purpose: packs variable-length bit fields LSB-first into OUT_WIDTH-bit words; flush pads and tags the last word.
// Latency: a word completed by the field accepted at edge k is presented after edge k+1 (if the output slot is free).
// Backpressure: out_data/out_last hold while out_valid && !out_ready; in_ready drops once a full word is buffered or a flush is pending.
module bit_field_packer #(
    parameter int   OUT_WIDTH   = 16,
    parameter int   FIELD_WIDTH = 11,
    parameter logic PAD_BIT     = 1'b0,
    localparam int  LEN_W       = $clog2(FIELD_WIDTH + 1),
    localparam int  FILL_W      = $clog2(OUT_WIDTH + FIELD_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FIELD_WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0]       in_len,
    input  logic                   in_flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FILL_W-1:0]      out_fill
);

    localparam int ACC_W = OUT_WIDTH + FIELD_WIDTH;

    // Accumulator state
    logic [ACC_W-1:0]     r_acc;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_flush_pending;

    // One-deep output register
    logic [OUT_WIDTH-1:0] r_out_data;
    logic                 r_out_last;
    logic                 r_out_valid;

    logic [LEN_W-1:0]       w_len;
    logic [FIELD_WIDTH-1:0] w_field;
    logic [ACC_W-1:0]       w_field_shifted;
    logic [OUT_WIDTH-1:0]   w_emit_data;
    logic                   w_full;
    logic                   w_accept;
    logic                   w_slot_free;
    logic                   w_emit;
    logic                   w_emit_last;

    // Oversized lengths saturate at the widest legal field.
    assign w_len = (in_len > LEN_W'(FIELD_WIDTH)) ? LEN_W'(FIELD_WIDTH) : in_len;

    // Zero every field bit at or above the effective length so stray high bits never pollute later fields.
    always_comb begin
        w_field = '0;
        for (int i = 0; i < FIELD_WIDTH; i++) begin
            w_field[i] = in_data[i] & (LEN_W'(i) < w_len);
        end
    end

    assign w_field_shifted = ACC_W'(w_field) << r_fill;

    // in_ready looks only at registered state, so there is no in_valid/out_ready -> in_ready path.
    assign w_full      = (r_fill >= FILL_W'(OUT_WIDTH));
    assign in_ready    = !w_full && !r_flush_pending;
    assign w_accept    = in_valid && in_ready;
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_emit      = w_slot_free && (w_full || (r_flush_pending && (r_fill != '0)));
    // A flush residue that fits in one word closes the stream; an overflowing one needs a second word.
    assign w_emit_last = r_flush_pending && (r_fill <= FILL_W'(OUT_WIDTH));

    // Build the outgoing word: unfilled positions of a partial word take the pad value.
    always_comb begin
        w_emit_data = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w_emit_data[i] = (FILL_W'(i) < r_fill) ? r_acc[i] : PAD_BIT;
        end
    end

    // Accumulator: append accepted fields, drop a word's worth of bits on emit, retire empty flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc           <= '0;
            r_fill          <= '0;
            r_flush_pending <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= r_acc | w_field_shifted;
            r_fill <= r_fill + FILL_W'(w_len);
            if (in_flush) begin
                r_flush_pending <= 1'b1;
            end
        end else if (w_emit) begin
            r_acc  <= r_acc >> OUT_WIDTH;
            r_fill <= w_full ? (r_fill - FILL_W'(OUT_WIDTH)) : '0;
            if (w_emit_last) begin
                r_flush_pending <= 1'b0;
            end
        end else if (r_flush_pending && (r_fill == '0)) begin
            r_flush_pending <= 1'b0;
        end
    end

    // Output register: load a new word whenever the slot frees up, otherwise go idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_slot_free) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_data <= w_emit_data;
                r_out_last <= w_emit_last;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign out_fill  = r_fill;

endmodule

// File: tb/tb_bit_field_packer.sv
// Purpose: checks bit_field_packer (pad 0 and pad 1 instances side by side) against a bit-queue reference model.
// Latency: directed checks pin word timing one edge after completion; the scoreboard checks word order and content.
// Backpressure: out_ready is held, released, and randomized; a held word must keep matching the expected word.
module tb_bit_field_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] in_data;
    logic [3:0]  in_len;
    logic        in_flush;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic [15:0] out_data0, out_data1;
    logic        out_last0, out_last1;
    logic        out_valid0, out_valid1;
    logic [4:0]  out_fill0, out_fill1;

    int n_chk  = 0;
    int n_fail = 0;
    logic rand_rdy = 1'b0;

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic        last;
    } exp_t;

    bit   bitq[$];
    exp_t expq[$];

    always #5 clk = ~clk;

    bit_field_packer #(.OUT_WIDTH(16), .FIELD_WIDTH(11), .PAD_BIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_flush(in_flush),
        .in_valid(in_valid), .in_ready(in_ready0), .out_data(out_data0), .out_last(out_last0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_fill(out_fill0)
    );

    bit_field_packer #(.OUT_WIDTH(16), .FIELD_WIDTH(11), .PAD_BIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_flush(in_flush),
        .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1), .out_last(out_last1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_fill(out_fill1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the stream is just an ordered list of bits; every 16 bits make a word,
    // and a flush turns whatever is left into one padded word tagged last.
    task automatic model_accept(input logic [10:0] d, input int l, input logic f);
        int   len;
        exp_t e;
        len = (l > 11) ? 11 : l;
        for (int i = 0; i < len; i++) bitq.push_back(d[i]);
        while (bitq.size() >= 16) begin
            for (int i = 0; i < 16; i++) e.d0[i] = bitq.pop_front();
            e.d1   = e.d0;
            e.last = f && (bitq.size() == 0);
            expq.push_back(e);
        end
        if (f && bitq.size() > 0) begin
            e.d0 = 16'h0000;
            e.d1 = 16'hFFFF;
            for (int i = 0; i < 16; i++) begin
                if (bitq.size() > 0) begin
                    e.d0[i] = bitq[0];
                    e.d1[i] = bitq.pop_front();
                end
            end
            e.last = 1'b1;
            expq.push_back(e);
        end
    endtask

    // Monitor at the falling edge: inputs and outputs are stable, handshakes complete at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            bitq.delete();
            expq.delete();
        end else begin
            if (out_valid0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_word", 32'(out_data0), 32'hDEAD_BEEF);
                end else begin
                    chk("word_pad0", 32'(out_data0), 32'(expq[0].d0));
                    chk("word_pad1", 32'(out_data1), 32'(expq[0].d1));
                    chk("word_last0", 32'(out_last0), 32'(expq[0].last));
                    chk("word_last1", 32'(out_last1), 32'(expq[0].last));
                    chk("valid_pad1", 32'(out_valid1), 32'd1);
                    if (out_ready) void'(expq.pop_front());
                end
            end
            if (in_valid && in_ready0) model_accept(in_data, int'(in_len), in_flush);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [10:0] d, input logic [3:0] l, input logic f);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        in_data  = d;
        in_len   = l;
        in_flush = f;
        in_valid = 1'b1;
        while (!done && n < 300) begin
            @(negedge clk);
            done = in_ready0;
            n++;
            tick();
        end
        in_valid = 1'b0;
        in_flush = 1'b0;
        in_len   = '0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_data = '0; in_len = '0; in_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid0), 32'd0);
        chk("rst_last", 32'(out_last0), 32'd0);
        chk("rst_data", 32'(out_data0), 32'd0);
        chk("rst_fill", 32'(out_fill0), 32'd0);
        chk("rst_ready", 32'(in_ready0), 32'd1);
        rst = 1'b0;

        // Packing across a word boundary
        send(11'h005, 4'd4, 1'b0);
        send(11'h3FF, 4'd10, 1'b0);
        send(11'h00F, 4'd4, 1'b0);
        chk("pack_fill_pre", 32'(out_fill0), 32'd18);
        tick();
        chk("pack_valid", 32'(out_valid0), 32'd1);
        chk("pack_data", 32'(out_data0), 32'hFFF5);
        chk("pack_last", 32'(out_last0), 32'd0);
        chk("pack_fill", 32'(out_fill0), 32'd2);

        // Zero-length flush closes the 2-bit residue
        send(11'h000, 4'd0, 1'b1);
        tick();
        chk("flush_data_pad0", 32'(out_data0), 32'h0003);
        chk("flush_data_pad1", 32'(out_data1), 32'hFFFF);
        chk("flush_last", 32'(out_last0), 32'd1);
        chk("flush_fill", 32'(out_fill0), 32'd0);
        tick();
        chk("flush_idle", 32'(out_valid0), 32'd0);
        chk("flush_ready", 32'(in_ready0), 32'd1);

        // Masking of high bits and clamping of oversized length
        send(11'h7FF, 4'd3, 1'b0);
        send(11'h7FF, 4'd15, 1'b1);
        chk("clamp_fill", 32'(out_fill0), 32'd14);
        tick();
        chk("clamp_data_pad0", 32'(out_data0), 32'h3FFF);
        chk("clamp_data_pad1", 32'(out_data1), 32'hFFFF);
        chk("clamp_last", 32'(out_last0), 32'd1);
        tick();
        tick();

        // Backpressure: a second full word waits in the accumulator
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(11'h00A, 4'd4, 1'b0);
        chk("bp_fill", 32'(out_fill0), 32'd16);
        chk("bp_ready", 32'(in_ready0), 32'd0);
        chk("bp_valid", 32'(out_valid0), 32'd1);
        chk("bp_data", 32'(out_data0), 32'hAAAA);
        tick();
        chk("bp_hold_data", 32'(out_data0), 32'hAAAA);
        chk("bp_hold_fill", 32'(out_fill0), 32'd16);
        out_ready = 1'b1;
        tick();
        chk("bp_reload_valid", 32'(out_valid0), 32'd1);
        chk("bp_reload_data", 32'(out_data0), 32'hAAAA);
        chk("bp_reload_fill", 32'(out_fill0), 32'd0);
        chk("bp_reload_ready", 32'(in_ready0), 32'd1);
        tick();
        chk("bp_drained", 32'(out_valid0), 32'd0);

        // Empty flush: no word, in_ready back after one cycle
        send(11'h7FF, 4'd0, 1'b1);
        chk("eflush_ready_lo", 32'(in_ready0), 32'd0);
        chk("eflush_valid", 32'(out_valid0), 32'd0);
        tick();
        chk("eflush_ready_hi", 32'(in_ready0), 32'd1);
        chk("eflush_valid2", 32'(out_valid0), 32'd0);

        // Asynchronous reset with a word held and 7 bits buffered
        out_ready = 1'b0;
        send(11'h7FF, 4'd11, 1'b0);
        send(11'h01F, 4'd5, 1'b0);
        send(11'h055, 4'd7, 1'b0);
        chk("mrst_pre_fill", 32'(out_fill0), 32'd7);
        chk("mrst_pre_valid", 32'(out_valid0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid0), 32'd0);
        chk("mrst_fill", 32'(out_fill0), 32'd0);
        chk("mrst_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(11'h003, 4'd2, 1'b1);
        tick();
        chk("mrst_post_data", 32'(out_data0), 32'h0003);
        chk("mrst_post_last", 32'(out_last0), 32'd1);
        tick();

        // Randomized traffic with random sink stalls, checked by the scoreboard
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(11'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end
        send(11'($urandom), 4'($urandom_range(0, 15)), 1'b1);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("end_expq_empty", 32'(expq.size()), 32'd0);
        chk("end_bitq_empty", 32'(bitq.size()), 32'd0);
        chk("end_fill", 32'(out_fill0), 32'd0);
        chk("end_idle", 32'(out_valid0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
